fpu_result_scoreboard: RTL and testbench

Synthesizable, parametrised result checker for the floating-point unit. It buffers a stream of expected results in a FIFO and pops one entry per valid FPU result. Each result is classified as match, rounding error (within an ULP tolerance) or mismatch, with saturating per-class counters and sticky error flags. It sits beside the FPU in bench and FPGA self-test builds, replacing file-based output checking.

---
 rtl/fpu_sb_pkg.sv | 33 +++
 rtl/fpu_result_scoreboard_if.sv | 23 ++
 rtl/fpu_sb_fifo.sv | 54 +++++
 rtl/fpu_result_scoreboard.sv | 117 +++++++++++
 tb/tb_fpu_result_scoreboard.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_sb_pkg.sv
// Shared types and helpers for the FPU result scoreboard: result class encoding,
// exponent/mantissa field widths per operand width, and NaN detection.
package fpu_sb_pkg;

  typedef enum logic [1:0] {
    CLS_NONE     = 2'd0,
    CLS_MATCH    = 2'd1,
    CLS_ROUND    = 2'd2,
    CLS_MISMATCH = 2'd3
  } last_class_e;

  function automatic int exp_width(input int width);
    return (width == 64) ? 11 : 8;
  endfunction

  function automatic int man_width(input int width);
    return width - 1 - exp_width(width);
  endfunction

  // Operand is passed zero-extended to 64 bits so one function serves both formats.
  function automatic logic is_nan(input logic [63:0] v, input int width);
    logic exp_ones;
    logic man_nz;
    exp_ones = 1'b1;
    man_nz   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < man_width(width)) man_nz = man_nz | v[i];
      else if (i < width - 1)   exp_ones = exp_ones & v[i];
    end
    return exp_ones && man_nz;
  endfunction

endpackage

// File: rtl/fpu_result_scoreboard_if.sv
// Expected-value stream and FPU result port of the result scoreboard.
interface fpu_result_scoreboard_if #(
  parameter int WIDTH = 32
);
  // exp: a word transfers on a rising edge where exp_valid && exp_ready; the
  // producer holds exp_data stable while waiting. res has no back-pressure:
  // res_data is consumed on every edge where res_valid is high.
  logic             exp_valid;
  logic             exp_ready;
  logic [WIDTH-1:0] exp_data;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;

  modport master (
    output exp_valid, exp_data, res_valid, res_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_data, res_valid, res_data,
    output exp_ready
  );
endinterface

// File: rtl/fpu_sb_fifo.sv
// Synchronous FIFO holding expected results; pointers wrap naturally and the
// occupancy is kept as a separate count.
module fpu_sb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/fpu_result_scoreboard.sv
// Checks FPU results against a queue of expected values, classing each as match,
// rounding error or mismatch. Define FPU_SB_NAN_EQUIV_EN to treat any NaN pair as a match.
module fpu_result_scoreboard
  import fpu_sb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int ULP_TOL = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  fpu_result_scoreboard_if.slave   sb,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         round_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [CNT_W-1:0]         orphan_cnt,
  output logic [1:0]               last_class,
  output logic                     err_sticky,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int AW = $clog2(DEPTH);

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;
  logic [AW:0]      w_count;
  logic [WIDTH-2:0] w_diff;
  logic             w_sign_eq;
  last_class_e      w_class;

  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_round_cnt;
  logic [CNT_W-1:0] r_mismatch_cnt;
  logic [CNT_W-1:0] r_orphan_cnt;
  last_class_e      r_last_class;
  logic             r_err_sticky;

  assign sb.exp_ready = !w_full;
  assign w_push       = sb.exp_valid && !w_full;
  assign w_pop        = sb.res_valid && !w_empty;

  fpu_sb_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (sb.exp_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Rounding distance ignores the sign; opposite signs are never a rounding error.
  always_comb begin
    w_sign_eq = (sb.res_data[WIDTH-1] == w_head[WIDTH-1]);
    w_diff    = (sb.res_data[WIDTH-2:0] > w_head[WIDTH-2:0])
              ? (sb.res_data[WIDTH-2:0] - w_head[WIDTH-2:0])
              : (w_head[WIDTH-2:0] - sb.res_data[WIDTH-2:0]);
    w_class   = CLS_MISMATCH;
    if (sb.res_data == w_head)
      w_class = CLS_MATCH;
    else if (w_sign_eq && (w_diff <= (WIDTH-1)'(ULP_TOL)))
      w_class = CLS_ROUND;
`ifdef FPU_SB_NAN_EQUIV_EN
    if (is_nan(64'(sb.res_data), WIDTH) && is_nan(64'(w_head), WIDTH))
      w_class = CLS_MATCH;
`endif
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_match_cnt    <= '0;
      r_round_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_orphan_cnt   <= '0;
      r_last_class   <= CLS_NONE;
      r_err_sticky   <= 1'b0;
    end else if (sb.res_valid) begin
      if (w_empty) begin
        r_orphan_cnt <= sat_inc(r_orphan_cnt);
        r_last_class <= CLS_MISMATCH;
        r_err_sticky <= 1'b1;
      end else begin
        r_last_class <= w_class;
        case (w_class)
          CLS_MATCH: r_match_cnt <= sat_inc(r_match_cnt);
          CLS_ROUND: r_round_cnt <= sat_inc(r_round_cnt);
          CLS_MISMATCH: begin
            r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
            r_err_sticky   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign match_cnt    = r_match_cnt;
  assign round_cnt    = r_round_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign orphan_cnt   = r_orphan_cnt;
  assign last_class   = r_last_class;
  assign err_sticky   = r_err_sticky;
  assign pending      = w_count;

endmodule

// File: tb/tb_fpu_result_scoreboard.sv
// Bench for fpu_result_scoreboard: directed scenarios plus random traffic checked
// against a queue-based reference model; a second instance uses 2-bit counters.
module tb_fpu_result_scoreboard;
  localparam int DEPTH   = 8;
  localparam int ULP_TOL = 1;
  localparam int CNT_MAX = 65535;

  logic clk;
  logic rst;

  logic [15:0] match_cnt, round_cnt, mismatch_cnt, orphan_cnt;
  logic [1:0]  last_class;
  logic        err_sticky;
  logic [3:0]  pending;

  logic [1:0]  s_match, s_round, s_mismatch, s_orphan;
  logic [1:0]  s_last_class;
  logic        s_err_sticky;
  logic [3:0]  s_pending;

  fpu_result_scoreboard_if #(.WIDTH(32)) ifc ();
  fpu_result_scoreboard_if #(.WIDTH(32)) ifs ();

  fpu_result_scoreboard #(.WIDTH(32), .DEPTH(DEPTH), .ULP_TOL(ULP_TOL), .CNT_W(16)) dut (
    .CLK (clk), .RST (rst), .sb (ifc),
    .match_cnt (match_cnt), .round_cnt (round_cnt), .mismatch_cnt (mismatch_cnt),
    .orphan_cnt (orphan_cnt), .last_class (last_class), .err_sticky (err_sticky),
    .pending (pending)
  );

  fpu_result_scoreboard #(.WIDTH(32), .DEPTH(DEPTH), .ULP_TOL(ULP_TOL), .CNT_W(2)) dut_sat (
    .CLK (clk), .RST (rst), .sb (ifs),
    .match_cnt (s_match), .round_cnt (s_round), .mismatch_cnt (s_mismatch),
    .orphan_cnt (s_orphan), .last_class (s_last_class), .err_sticky (s_err_sticky),
    .pending (s_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard / reference model
  logic [31:0] exp_q[$];
  int m_match, m_round, m_mis, m_orph, m_last;
  bit m_sticky;
  int n_checks, n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // 1 match, 2 rounding error, 3 mismatch
  function automatic int model_class(input logic [31:0] r, input logic [31:0] e);
    longint unsigned mr, me, d;
    mr = r[30:0];
    me = e[30:0];
    d  = (mr > me) ? mr - me : me - mr;
`ifdef FPU_SB_NAN_EQUIV_EN
    if (model_nan(r) && model_nan(e)) return 1;
`endif
    if (r == e) return 1;
    if (r[31] == e[31] && d <= ULP_TOL) return 2;
    return 3;
  endfunction

  function automatic int sat_add(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_match = 0; m_round = 0; m_mis = 0; m_orph = 0; m_last = 0; m_sticky = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pending"},      64'(pending),      64'(exp_q.size()));
    check({tag, ".exp_ready"},    64'(ifc.exp_ready), 64'(exp_q.size() < DEPTH));
    check({tag, ".match_cnt"},    64'(match_cnt),    64'(m_match));
    check({tag, ".round_cnt"},    64'(round_cnt),    64'(m_round));
    check({tag, ".mismatch_cnt"}, 64'(mismatch_cnt), 64'(m_mis));
    check({tag, ".orphan_cnt"},   64'(orphan_cnt),   64'(m_orph));
    check({tag, ".last_class"},   64'(last_class),   64'(m_last));
    check({tag, ".err_sticky"},   64'(err_sticky),   64'(m_sticky));
  endtask

  // driver: one clock on the main instance, model advanced from pre-edge state
  task automatic cycle(input bit ev, input logic [31:0] ed, input bit rv, input logic [31:0] rd);
    int sz;
    int cls;
    ifc.exp_valid = ev;
    ifc.exp_data  = ed;
    ifc.res_valid = rv;
    ifc.res_data  = rd;
    sz = exp_q.size();
    if (rv) begin
      if (sz == 0) begin
        m_orph = sat_add(m_orph); m_last = 3; m_sticky = 1;
      end else begin
        cls = model_class(rd, exp_q[0]);
        void'(exp_q.pop_front());
        m_last = cls;
        if (cls == 1) m_match = sat_add(m_match);
        else if (cls == 2) m_round = sat_add(m_round);
        else begin m_mis = sat_add(m_mis); m_sticky = 1; end
      end
    end
    if (ev && sz < DEPTH) exp_q.push_back(ed);
    @(posedge clk);
    #1;
    ifc.exp_valid = 1'b0;
    ifc.res_valid = 1'b0;
  endtask

  task automatic sat_cycle(input bit ev, input logic [31:0] ed, input bit rv, input logic [31:0] rd);
    ifs.exp_valid = ev;
    ifs.exp_data  = ed;
    ifs.res_valid = rv;
    ifs.res_data  = rd;
    @(posedge clk);
    #1;
    ifs.exp_valid = 1'b0;
    ifs.res_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] h, ed, rd;
    int mode;
    n_checks = 0;
    n_err    = 0;
    model_reset();
    rst = 1'b1;
    ifc.exp_valid = 0; ifc.exp_data = '0; ifc.res_valid = 0; ifc.res_data = '0;
    ifs.exp_valid = 0; ifs.exp_data = '0; ifs.res_valid = 0; ifs.res_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.const_ready", 64'(ifc.exp_ready), 64'd1);
    rst = 1'b0;

    // exact match
    cycle(1, 32'h3F800000, 0, '0);
    cycle(0, '0, 1, 32'h3F800000);
    check_all("match");
    check("match.cnt_is_1", 64'(match_cnt), 64'd1);
    check("match.class_is_1", 64'(last_class), 64'd1);

    // one-ULP rounding error, then a three-ULP mismatch
    cycle(1, 32'h40490FDB, 0, '0);
    cycle(0, '0, 1, 32'h40490FDC);
    check_all("round");
    check("round.cnt_is_1", 64'(round_cnt), 64'd1);
    check("round.sticky_0", 64'(err_sticky), 64'd0);
    cycle(1, 32'h40490FDB, 0, '0);
    cycle(0, '0, 1, 32'h40490FDE);
    check_all("mismatch");
    check("mismatch.cnt_is_1", 64'(mismatch_cnt), 64'd1);
    check("mismatch.sticky_1", 64'(err_sticky), 64'd1);

    // orphan: push in the same cycle must not be compared
    cycle(1, 32'h12345678, 1, 32'h12345678);
    check_all("orphan");
    check("orphan.cnt_is_1", 64'(orphan_cnt), 64'd1);
    check("orphan.pending_1", 64'(pending), 64'd1);
    cycle(0, '0, 1, 32'h12345678);
    check_all("orphan_drain");

    // fill to full, then push+pop together pops only
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h3F000000 + i, 0, '0);
    check_all("full");
    check("full.ready_0", 64'(ifc.exp_ready), 64'd0);
    cycle(1, 32'hDEADBEEF, 1, 32'h3F000000);
    check_all("full_pushpop");
    check("full_pushpop.pending_7", 64'(pending), 64'd7);
    check("full_pushpop.ready_1", 64'(ifc.exp_ready), 64'd1);
    for (int i = 1; i < DEPTH; i++) cycle(0, '0, 1, 32'h3F000000 + i);
    check_all("full_drain");

    // NaN pair with differing sign and payload
    cycle(1, 32'h7FC00000, 0, '0);
    cycle(0, '0, 1, 32'hFFC00001);
    check_all("nan");
`ifdef FPU_SB_NAN_EQUIV_EN
    check("nan.class", 64'(last_class), 64'd1);
`else
    check("nan.class", 64'(last_class), 64'd3);
`endif

    // random traffic
    for (int n = 0; n < 500; n++) begin
      ed = $urandom();
      if ($urandom_range(0, 7) == 0) ed = {ed[31], 8'hFF, ed[22:1], 1'b1};
      rd = $urandom();
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        mode = $urandom_range(0, 7);
        case (mode)
          0, 1: rd = h;
          2: rd = h + 32'd1;
          3: rd = h - 32'd1;
          4: rd = h + 32'd2;
          5: rd = {~h[31], h[30:0]};
          6: rd = {rd[31], 8'hFF, rd[22:1], 1'b1};
          default: ;
        endcase
      end
      cycle($urandom_range(0, 99) < 55, ed, $urandom_range(0, 99) < 50, rd);
      check_all("random");
    end

    // saturation on the 2-bit-counter instance
    for (int i = 0; i < 4; i++) begin
      sat_cycle(1, 32'h3F800000 + i, 0, '0);
      sat_cycle(0, '0, 1, 32'h3F800000 + i);
    end
    check("sat.match_3", 64'(s_match), 64'd3);
    sat_cycle(1, 32'h1, 0, '0);
    sat_cycle(0, '0, 1, 32'h1);
    check("sat.match_hold", 64'(s_match), 64'd3);
    check("sat.sticky_0", 64'(s_err_sticky), 64'd0);

    // asynchronous reset mid-stream
    cycle(1, 32'h11111111, 0, '0);
    cycle(1, 32'h22222222, 1, 32'h11111111);
    cycle(1, 32'h33333333, 0, '0);
    sat_cycle(1, 32'h5, 0, '0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.sat_match", 64'(s_match), 64'd0);
    check("async_rst.sat_pending", 64'(s_pending), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, '0, 1, 32'h22222222);
    check_all("post_rst");
    check("post_rst.orphan_1", 64'(orphan_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
